// File: rtl/icache_pkg.sv
`default_nettype none
//----------------------------------------------------------------------
// icache_pkg : shared memory-bus defines for the icache slice | rev 1.0
//----------------------------------------------------------------------
package icache_pkg;

  localparam logic MEM_READ      = 1'b0;
  localparam logic MEM_WRITE     = 1'b1;
  localparam logic TRUE          = 1'b1;
  localparam logic FALSE         = 1'b0;
  localparam logic OP_SIZE_BLOCK = 1'b0;
  localparam logic OP_SIZE_USER  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/icache_if.sv
`default_nettype none
//----------------------------------------------------------------------
// icache_if : CPU fetch port plus memory-controller refill bus | rev 1.0
//----------------------------------------------------------------------
interface icache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);

  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data;
  logic                  cpu_valid;
  logic                  cpu_stall;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_enable;
  logic                  mem_rw;
  logic                  mem_op_size;
  logic                  mem_finishes_op;
  logic [DATA_WIDTH-1:0] mem_data_read;
  logic                  mem_data_read_valid;
  logic                  mem_finished;

  // master is the environment (CPU + memory controller), slave is the cache
  modport master (
    output cpu_req, cpu_addr, flush, mem_data_read, mem_data_read_valid, mem_finished,
    input  cpu_data, cpu_valid, cpu_stall, mem_addr, mem_enable, mem_rw, mem_op_size,
           mem_finishes_op
  );

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_data_read, mem_data_read_valid, mem_finished,
    output cpu_data, cpu_valid, cpu_stall, mem_addr, mem_enable, mem_rw, mem_op_size,
           mem_finishes_op
  );

endinterface
`default_nettype wire

// File: rtl/icache_line_ram.sv
`default_nettype none
//----------------------------------------------------------------------
// icache_line_ram : one cache line, sync write / async read  | rev 1.0
//----------------------------------------------------------------------
module icache_line_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [OFFSET_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [OFFSET_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int WORDS = 1 << OFFSET_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
//----------------------------------------------------------------------
// icache : direct-mapped instruction cache with block refill | rev 1.0
//----------------------------------------------------------------------
module icache
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int INDEX_WIDTH  = 3,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  icache_if.slave  bus
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_WIDTH-1:0]    tag_q [LINES];
  logic [TAG_WIDTH-1:0]    tag_d [LINES];
  logic [TAG_WIDTH-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_WIDTH-1:0]  miss_index_q, miss_index_d;
  logic [OFFSET_WIDTH:0]   cnt_q, cnt_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    mem_enable_q, mem_enable_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

  logic                    ram_we;
  logic                    cpu_valid;
  logic                    cpu_stall;
  logic                    hit;
  logic [DATA_WIDTH-1:0]   line_rdata [LINES];

  logic [TAG_WIDTH-1:0]    lookup_tag;
  logic [INDEX_WIDTH-1:0]  lookup_index;
  logic [OFFSET_WIDTH-1:0] lookup_offset;

  assign lookup_tag    = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign lookup_index  = bus.cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign lookup_offset = bus.cpu_addr[OFFSET_WIDTH-1:0];
  assign hit           = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    mem_enable_d = FALSE;
    mem_addr_d   = mem_addr_q;
    ram_we       = FALSE;
    cpu_valid    = FALSE;
    cpu_stall    = FALSE;

    case (state_q)
      S_IDLE: begin
        cpu_stall = bus.cpu_req && !hit;
        if (bus.flush) begin
          valid_d = '0;
        end else if (bus.cpu_req && hit) begin
          cpu_valid = TRUE;
        end else if (bus.cpu_req) begin
          // The line is invalidated up front so an abandoned refill never looks valid.
          state_d               = S_REFILL;
          miss_tag_d            = lookup_tag;
          miss_index_d          = lookup_index;
          mem_addr_d            = {lookup_tag, lookup_index, {OFFSET_WIDTH{1'b0}}};
          mem_enable_d          = TRUE;
          cnt_d                 = '0;
          valid_d[lookup_index] = FALSE;
        end
      end

      S_REFILL: begin
        cpu_stall = TRUE;
        if (bus.flush) begin
          flush_pend_d = TRUE;
        end
        // Top counter bit marks a full line; surplus data beats are dropped.
        if (bus.mem_data_read_valid && !cnt_q[OFFSET_WIDTH]) begin
          ram_we = TRUE;
          cnt_d  = cnt_q + (OFFSET_WIDTH+1)'(1);
        end
        if (bus.mem_finished) begin
          state_d               = S_DONE;
          valid_d[miss_index_q] = TRUE;
          tag_d[miss_index_q]   = miss_tag_q;
        end
      end

      S_DONE: begin
        cpu_stall    = TRUE;
        state_d      = S_IDLE;
        flush_pend_d = FALSE;
        if (flush_pend_q || bus.flush) begin
          valid_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      cnt_q        <= '0;
      flush_pend_q <= FALSE;
      mem_enable_q <= FALSE;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      mem_enable_q <= mem_enable_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    icache_line_ram #(
      .DATA_WIDTH   (DATA_WIDTH),
      .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_line_ram (
      .clk   (clk),
      .we    (ram_we && (miss_index_q == INDEX_WIDTH'(gi))),
      .waddr (cnt_q[OFFSET_WIDTH-1:0]),
      .wdata (bus.mem_data_read),
      .raddr (lookup_offset),
      .rdata (line_rdata[gi])
    );
  end

  assign bus.cpu_data        = line_rdata[lookup_index];
  assign bus.cpu_valid       = cpu_valid;
  assign bus.cpu_stall       = cpu_stall;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_enable      = mem_enable_q;
  assign bus.mem_rw          = MEM_READ;
  assign bus.mem_op_size     = OP_SIZE_BLOCK;
  assign bus.mem_finishes_op = FALSE;

endmodule
`default_nettype wire
